// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state type and default sizing for adder_arbiter.
// Holds arb_state_e and the ARB_SIZE_DEF / ARB_NREQ_DEF defaults.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  localparam int ARB_SIZE_DEF = 8;
  localparam int ARB_NREQ_DEF = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant plus encoded index, search starts at ptr.
// Ports: req, ptr, en in; gnt, idx out. ADDER_ARB_FIXED_PRIO_EN: lowest wins.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef ADDER_ARB_FIXED_PRIO_EN
  input  logic [IDW-1:0]  ptr,
`endif
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] j;
  int             s;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    s     = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      s = i;
`else
      // Rotate the search origin; wrap explicitly so
      // non-power-of-two NREQ never indexes past the end.
      s = int'(ptr) + i;
      if (s >= NREQ) s = s - NREQ;
`endif
      j = IDW'(s);
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/signed_adder.sv
// signed_adder: two's-complement add with one guard bit and overflow flag.
// Ports: a, b (SIZE) in; result (SIZE+1) full sum; overflow on SIZE-bit wrap.
module signed_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   result,
  output logic            overflow
);

  assign result = {a[SIZE-1], a} + {b[SIZE-1], b};

  // A SIZE-bit result would wrap when both operand signs agree
  // but the truncated sum's sign differs from them.
  assign overflow = (a[SIZE-1] == b[SIZE-1]) &&
                    (result[SIZE-1] != a[SIZE-1]);

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one signed_adder among NREQ valid/ready requesters.
// Ports: req_valid/ready/a/b in; rsp_valid/ready/id/result/overflow, busy out.
// ADDER_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int SIZE = ARB_SIZE_DEF,
  parameter  int NREQ = ARB_NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [SIZE:0]      rsp_result,
  output logic               rsp_overflow,
  output logic               busy
);

  arb_state_e      state;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [SIZE:0]   sum;
  logic            ovf;
  logic            arb_en;

`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  rr_ptr;
`endif

  // Gated by rst_n so nothing is offered while reset is held.
  assign arb_en    = (state == IDLE) && rst_n;
  assign req_ready = gnt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req_valid),
`ifndef ADDER_ARB_FIXED_PRIO_EN
    .ptr (rr_ptr),
`endif
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  signed_adder #(
    .SIZE (SIZE)
  ) u_add (
    .a        (op_a),
    .b        (op_b),
    .result   (sum),
    .overflow (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      id_q         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      busy         <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      rr_ptr       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            op_a  <= req_a[gnt_idx*SIZE +: SIZE];
            op_b  <= req_b[gnt_idx*SIZE +: SIZE];
            id_q  <= gnt_idx;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= sum;
          rsp_overflow <= ovf;
          rsp_id       <= id_q;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            if (id_q == IDW'(NREQ-1)) rr_ptr <= '0;
            else                      rr_ptr <= id_q + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `signed_adder` instance between `NREQ` requesters with valid/ready handshakes on both sides. Each accepted request carries two signed operands. The block latches them and computes the sum and overflow in a dedicated cycle. It then holds the registered result, tagged with the requester index, until the consumer accepts it. It sits between the ALU's operand sources and the shared adder datapath.

## Interface
Parameters:
- `SIZE`, 8, operand width in bits; passed unchanged to `signed_adder`.
- `NREQ`, 4, number of requesters; legal range 2..8.
- `IDW`, `$clog2(NREQ)` (localparam), width of the requester index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- `req_a`  in  NREQ*SIZE  operand A; requester i uses bits [i*SIZE +: SIZE].
- `req_b`  in  NREQ*SIZE  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_result`  out  SIZE+1  `signed_adder` result, registered.
- `rsp_overflow`  out  1  `signed_adder` overflow flag, registered.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` bit is high, select grant g by round-robin, starting the search at `rr_ptr`.
  - Drive `req_ready[g]=1` combinationally in the same cycle.
  - On the clock edge: latch `req_a[g]`, `req_b[g]` and g into `op_a`, `op_b`, `id_q`; move to EXEC.
  - If no request is valid, remain in IDLE with `req_ready` all zero.
- **EXEC:**
  - The adder sees `op_a` and `op_b`.
  - On the clock edge: register its `result` and `overflow` into `rsp_result` and `rsp_overflow`; copy `id_q` to `rsp_id`; move to RESP.
- **RESP:**
  - `rsp_valid=1`.
  - While `rsp_ready=0`, all response outputs are held stable.
  - On `rsp_valid && rsp_ready`: set `rr_ptr` to (`id_q`+1) mod NREQ, wrapping from NREQ-1 to 0, and return to IDLE.
- `req_ready` is zero in EXEC and RESP. Requests raised during those states wait.
- Requesters must hold `req_valid` and their operands until accepted. The block never drops a granted request.
- Arithmetic width and overflow semantics are exactly those of `signed_adder`. Nothing is truncated or sign-adjusted here.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_overflow`=0, `busy`=0, `rr_ptr`=0, `op_a`=0, `op_b`=0, `id_q`=0.
- **Reset asserted mid-operation** (EXEC or RESP): the transaction is discarded, all of the above return to reset values immediately, and no response is produced after reset is released.

## Timing
- Accept in cycle N (IDLE, handshake) -> EXEC in cycle N+1 -> `rsp_valid` high in cycle N+2.
- Minimum spacing between accepts is 3 cycles, reached when `rsp_ready` is high on the first RESP cycle.
- Returning to IDLE takes a full cycle. A new grant is never issued in the same cycle as a response handshake.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr` and the state. All other outputs come straight from registers.

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - The lowest valid index always wins.
  - `rr_ptr` is removed and `rsp_id` is unaffected.
- `ADDER_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Structure
- Package `adder_arb_pkg` holds:
  - the state enum `arb_state_e` {IDLE, EXEC, RESP};
  - the default constants `ARB_SIZE_DEF`=8 and `ARB_NREQ_DEF`=4.
- Sub-module `rr_arbiter` (parameter NREQ) contains:
  - inputs: request vector, pointer, enable;
  - output: one-hot grant plus encoded index;
  - fixed-priority logic when the macro is defined.
- The top level instantiates `rr_arbiter` once and `signed_adder #(SIZE)` once.

## Test plan
All scenarios use SIZE=8, NREQ=4.
- **Single request:** `req_valid[0]=1`, a=8'h05, b=8'h03, `rsp_ready`=1. Required: `req_ready[0]` high in cycle 0; `rsp_valid` in cycle 2 with `rsp_result`=9'h008, `rsp_overflow`=0, `rsp_id`=0.
- **Overflow pass-through:** `req_valid[2]=1`, a=8'h7F, b=8'h01. Required: `rsp_result`=9'h080, `rsp_overflow`=1, `rsp_id`=2.
- **Round-robin fairness:** all four `req_valid` held high, `rsp_ready`=1. Required: grants issued in order 0,1,2,3,0, one accept every 3 cycles. With the macro defined: always 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles during RESP. Required: `rsp_*` stable, `busy`=1, `req_ready`=0 throughout; handshake completes on the cycle `rsp_ready` rises; IDLE follows.
- **Reset mid-operation:** assert `rst_n`=0 while in EXEC. Required: `rsp_valid` stays 0; all outputs read their reset values; `rr_ptr`=0; after release, the next grant goes to the lowest valid index.
